// File: rtl/count_event_fifo.sv
// Wrap/direction-change event monitor for an up/down modulo-N counter, with a timestamped FWFT event FIFO.
// Optional build macro EVT_DROP_COUNT_EN enables the saturating dropped-event counter on drop_cnt.
module count_event_fifo #(
    parameter  int CNT_W = 4,
    parameter  int TS_W  = 12,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count,
    input  logic [CNT_W-1:0]  N,
    input  logic              up,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [TS_W+1:0]   evt_data,
    output logic [AW:0]       evt_level,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_WRAP_UP = 2'b01,
        EVT_WRAP_DN = 2'b10,
        EVT_DIR     = 2'b11
    } evt_type_e;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_prev_count;
    logic             r_prev_up;
    logic             r_armed;
    logic [TS_W+1:0]  r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_overflow;

    evt_type_e        w_type;
    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic             w_empty;
    logic             w_full;
    logic             w_unused;

    // Wrap detection deliberately ignores N, so a modulus change still reports jumps to/from zero.
    assign w_unused = ^N;

    always_comb begin
        w_type = EVT_NONE;
        if (r_armed) begin
            if (up != r_prev_up)
                w_type = EVT_DIR;
            else if (up && (count == '0) && (r_prev_count != '0))
                w_type = EVT_WRAP_UP;
            else if (!up && (r_prev_count == '0) && (count != '0))
                w_type = EVT_WRAP_DN;
        end
    end

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_push  = (w_type != EVT_NONE);
    assign w_pop   = !w_empty && evt_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts         <= '0;
            r_prev_count <= '0;
            r_prev_up    <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_ts         <= r_ts + TS_W'(1);
            r_prev_count <= count;
            r_prev_up    <= up;
            r_armed      <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the output is gated to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {w_type, r_ts};
    end

    assign evt_valid = !w_empty;
    assign evt_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign evt_level = r_level;
    assign overflow  = r_overflow;

`ifdef EVT_DROP_COUNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_count_event_fifo.sv
// Directed self-checking bench for count_event_fifo: wrap/dir detection, timestamps, FIFO full/drop and async reset.
module tb_count_event_fifo;

    logic        clk;
    logic        reset;
    logic [3:0]  count;
    logic [3:0]  N;
    logic        up;
    logic        evt_valid;
    logic        evt_ready;
    logic [13:0] evt_data;
    logic [2:0]  evt_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int          checks;
    int          errors;
    logic [11:0] ts_model;
    logic [11:0] ts_log [6];

`ifdef EVT_DROP_COUNT_EN
    localparam logic [7:0] EXP_DROP = 8'd2;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    count_event_fifo #(.CNT_W(4), .TS_W(12), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .N         (N),
        .up        (up),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_level (evt_level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        ts_model = ts_model + 12'd1;
        #1;
    endtask

    // Reset mid-cycle with count=0/up=1, release, then take the arming edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; count = 4'd0; N = 4'd4; up = 1'b1; evt_ready = 1'b0;
        #3;
        reset = 1'b1;
        ts_model = 12'd0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", evt_valid); end
        checks++; if (evt_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", evt_level); end
        checks++; if (evt_data !== 14'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", evt_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_wrap_up();
        logic [11:0] ts_exp;
        do_reset();
        evt_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            count = 4'(i);
            tick();
            checks++; if (evt_level !== 3'd0) begin errors++; $display("FAIL wrapup_noevt%0d: got %0d exp 0", i, evt_level); end
        end
        count = 4'd0;
        ts_exp = ts_model;
        tick();
        checks++; if (evt_level !== 3'd1) begin errors++; $display("FAIL wrapup_level: got %0d exp 1", evt_level); end
        checks++; if (evt_data !== {2'b01, ts_exp}) begin errors++; $display("FAIL wrapup_data: got %h exp %h", evt_data, {2'b01, ts_exp}); end
        tick();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL wrapup_drained: got %b exp 0", evt_valid); end
    endtask

    task automatic test_dir_then_wrap_dn();
        logic [11:0] ts_a;
        logic [11:0] ts_b;
        do_reset();
        count = 4'd1; tick();
        count = 4'd2; tick();
        up = 1'b0; ts_a = ts_model; tick();
        checks++; if (evt_data !== {2'b11, ts_a}) begin errors++; $display("FAIL t3_dir: got %h exp %h", evt_data, {2'b11, ts_a}); end
        count = 4'd1; tick();
        count = 4'd0; tick();
        checks++; if (evt_level !== 3'd1) begin errors++; $display("FAIL t3_mid_level: got %0d exp 1", evt_level); end
        count = 4'd3; ts_b = ts_model; tick();
        checks++; if (evt_level !== 3'd2) begin errors++; $display("FAIL t3_peak_level: got %0d exp 2", evt_level); end
        evt_ready = 1'b1; tick();
        checks++; if (evt_data !== {2'b10, ts_b}) begin errors++; $display("FAIL t3_wrapdn: got %h exp %h", evt_data, {2'b10, ts_b}); end
        tick();
        checks++; if (evt_level !== 3'd0) begin errors++; $display("FAIL t3_end_level: got %0d exp 0", evt_level); end
    endtask

    task automatic test_priority();
        logic [11:0] ts_exp;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            count = 4'(i); tick();
        end
        count = 4'd0; up = 1'b0; ts_exp = ts_model; tick();
        checks++; if (evt_level !== 3'd1) begin errors++; $display("FAIL prio_level: got %0d exp 1", evt_level); end
        checks++; if (evt_data !== {2'b11, ts_exp}) begin errors++; $display("FAIL prio_data: got %h exp %h", evt_data, {2'b11, ts_exp}); end
        tick();
        checks++; if (evt_level !== 3'd1) begin errors++; $display("FAIL prio_hold: got %0d exp 1", evt_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            up = ~up; ts_log[i] = ts_model; tick();
            if (i == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", overflow); end
            end
        end
        checks++; if (evt_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d exp 4", evt_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
        checks++; if (drop_cnt !== EXP_DROP) begin errors++; $display("FAIL ovf_drop: got %0d exp %0d", drop_cnt, EXP_DROP); end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (evt_data !== {2'b11, ts_log[i]}) begin errors++; $display("FAIL ovf_drain%0d: got %h exp %h", i, evt_data, {2'b11, ts_log[i]}); end
            tick();
        end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b exp 0", evt_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
        evt_ready = 1'b0;
    endtask

    // Runs without a fresh reset so the sticky overflow from the previous test is also cleared here.
    task automatic test_async_reset();
        up = ~up; tick();
        up = ~up; tick();
        checks++; if (evt_level !== 3'd2) begin errors++; $display("FAIL areset_pre: got %0d exp 2", evt_level); end
        reset = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b exp 0", evt_valid); end
        checks++; if (evt_level !== 3'd0) begin errors++; $display("FAIL areset_level: got %0d exp 0", evt_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_ovf: got %b exp 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL areset_drop: got %0d exp 0", drop_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            up = ~up; ts_log[i] = ts_model; tick();
        end
        evt_ready = 1'b1; up = ~up; ts_log[4] = ts_model; tick();
        checks++; if (evt_level !== 3'd4) begin errors++; $display("FAIL fpp_level: got %0d exp 4", evt_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b exp 0", overflow); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (evt_data !== {2'b11, ts_log[i]}) begin errors++; $display("FAIL fpp_drain%0d: got %h exp %h", i, evt_data, {2'b11, ts_log[i]}); end
            tick();
        end
        checks++; if (evt_level !== 3'd0) begin errors++; $display("FAIL fpp_end: got %0d exp 0", evt_level); end
    endtask

    initial begin
        checks = 0; errors = 0; ts_model = 12'd0;
        reset = 1'b0; count = 4'd0; N = 4'd4; up = 1'b1; evt_ready = 1'b0;
        test_reset();
        test_wrap_up();
        test_dir_then_wrap_dn();
        test_priority();
        test_overflow();
        test_async_reset();
        test_full_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
